// File: rtl/memc_pkg.sv
// rtl/memc_pkg.sv - shared state type and helpers for mem_c_drain
package memc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } memc_state_t;

   // width of a row/column index for a DEPTH x DEPTH matrix, never below one bit
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // clamp a signed value into the range of a signed field of the given width
   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                    input int bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bits - 1));
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/skew_delay.sv
// rtl/skew_delay.sv - enable-gated delay line of LEN registers (LEN=0 is a wire)
module skew_delay #(
   parameter int BITS = 24,
   parameter int LEN  = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [BITS-1:0] sample,
   output logic [BITS-1:0] delayed
);

   generate
      if (LEN == 0) begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst, en};
         assign delayed     = sample;
      end else begin : g_line
         logic [BITS-1:0] stage [LEN];

         // shift one slot per enabled beat; reset empties the line
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < LEN; i++) begin
                  stage[i] <= '0;
               end
            end else if (en) begin
               stage[0] <= sample;
               for (int i = 1; i < LEN; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign delayed = stage[LEN-1];
      end
   endgenerate

endmodule

// File: rtl/mem_c_drain.sv
// rtl/mem_c_drain.sv - de-skews systolic result lanes into a readable C buffer (option: MEMC_SATURATE_EN)
module mem_c_drain
   import memc_pkg::*;
#(
   parameter int BITS_C = 24,
   parameter int DEPTH  = 8
`ifdef MEMC_SATURATE_EN
   , parameter int BITS_OUT = 8
`endif
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic                              start,
   input  logic [DEPTH-1:0][BITS_C-1:0]      Cin,
   input  logic                              rd_en,
   input  logic [idx_width(DEPTH)-1:0]       row,
   input  logic [idx_width(DEPTH)-1:0]       col,
`ifdef MEMC_SATURATE_EN
   output logic signed [BITS_OUT-1:0]        Cout,
`else
   output logic signed [BITS_C-1:0]          Cout,
`endif
   output logic                              rd_valid,
   output logic                              busy,
   output logic                              done
);

   localparam int                IDX_W      = idx_width(DEPTH);
   localparam int                BEAT_W     = $clog2(2 * DEPTH);
   localparam logic [BEAT_W-1:0] FIRST_WR   = BEAT_W'(DEPTH - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(2 * DEPTH - 2);
   localparam bit                FULL_RANGE = (DEPTH == (1 << IDX_W));

   memc_state_t               state;
   memc_state_t               state_next;
   logic [BEAT_W-1:0]         beat;
   logic                      step;
   logic [BITS_C-1:0]         aligned [DEPTH];
   logic [BITS_C-1:0]         mem [DEPTH][DEPTH];
   logic [BEAT_W-1:0]         wr_off;
   logic                      wr_active;
   logic                      in_range;
   logic                      honour_rd;
   logic signed [BITS_C-1:0]  rd_word;

   // a beat is an enabled CAPTURE cycle; everything in the capture path keys off it
   assign step      = (state == CAPTURE) && en;
   assign wr_off    = beat - FIRST_WR;
   assign wr_active = step && (beat >= FIRST_WR);
   // a start in DONE leaves DONE on this edge, so a read in the same cycle is dropped
   assign honour_rd = (state == DONE) && rd_en && !start;

   // lane x is x beats late, so it gets DEPTH-1-x beats of delay to line up with lane DEPTH-1
   generate
      for (genvar x = 0; x < DEPTH; x++) begin : g_lane
         skew_delay #(
            .BITS (BITS_C),
            .LEN  (DEPTH - 1 - x)
         ) u_skew (
            .clk     (clk),
            .rst     (rst),
            .en      (step),
            .sample  (Cin[x]),
            .delayed (aligned[x])
         );
      end
   endgenerate

   // only a non-power-of-two DEPTH leaves address codes past the matrix edge
   generate
      if (FULL_RANGE) begin : g_full
         assign in_range = 1'b1;
      end else begin : g_part
         assign in_range = (row < IDX_W'(DEPTH)) && (col < IDX_W'(DEPTH));
      end
   endgenerate

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next state: start launches a capture from IDLE or DONE, the last beat completes it
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            if (step && (beat == LAST_BEAT)) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // beat counter: cleared when a capture launches, advances on each beat
   always_ff @(posedge clk) begin
      if (rst) begin
         beat <= '0;
      end else if ((state != CAPTURE) && start) begin
         beat <= '0;
      end else if (step) begin
         beat <= beat + BEAT_W'(1);
      end
   end

   // result buffer: each aligned row lands in a single write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < DEPTH; c++) begin
               mem[r][c] <= '0;
            end
         end
      end else if (wr_active) begin
         for (int c = 0; c < DEPTH; c++) begin
            mem[wr_off[IDX_W-1:0]][c] <= aligned[c];
         end
      end
   end

   // addressed element, zero past the matrix edge
   always_comb begin
      rd_word = '0;
      if (in_range) begin
         rd_word = mem[row][col];
      end
   end

`ifdef MEMC_SATURATE_EN
   logic signed [63:0]         sat_wide;
   logic signed [BITS_OUT-1:0] sat_out;
   logic                       unused_sat_hi;
   assign sat_wide      = sat_clamp({{(64 - BITS_C){rd_word[BITS_C-1]}}, rd_word}, BITS_OUT);
   assign sat_out       = sat_wide[BITS_OUT-1:0];
   assign unused_sat_hi = ^sat_wide[63:BITS_OUT];
`endif

   // status flags follow the state being entered so they line up with the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next == CAPTURE);
         done <= (state_next == DONE);
      end
   end

   // read register: one-cycle latency, data holds when no read is honoured
   always_ff @(posedge clk) begin
      if (rst) begin
         Cout     <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= honour_rd;
         if (honour_rd) begin
`ifdef MEMC_SATURATE_EN
            Cout <= sat_out;
`else
            Cout <= rd_word;
`endif
         end
      end
   end

endmodule

// File: tb/tb_mem_c_drain.sv
// tb/tb_mem_c_drain.sv - directed self-checking bench for mem_c_drain
module tb_mem_c_drain;

   localparam int BITS_C = 24;
   localparam int DEPTH  = 8;
   localparam int NBEATS = 2 * DEPTH - 1;
`ifdef MEMC_SATURATE_EN
   localparam int OUT_W  = 8;
`else
   localparam int OUT_W  = BITS_C;
`endif

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          en;
   logic                          start;
   logic [DEPTH-1:0][BITS_C-1:0]  cin;
   logic                          rd_en;
   logic [2:0]                    row;
   logic [2:0]                    col;
   logic signed [OUT_W-1:0]       cout;
   logic                          rd_valid;
   logic                          busy;
   logic                          done;

   int n_checks = 0;
   int n_fail   = 0;
   int stim [DEPTH][DEPTH];

   // behavioural model: phase 0 idle, 1 capturing, 2 matrix complete
   int  m_phase = 0;
   int  m_beats = 0;
   int  m_cout  = 0;
   bit  m_valid = 1'b0;
   int  m_mat [DEPTH][DEPTH];
   bit  chk_on  = 1'b0;

   always #5 clk = ~clk;

   mem_c_drain #(
      .BITS_C (BITS_C),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .start    (start),
      .Cin      (cin),
      .rd_en    (rd_en),
      .row      (row),
      .col      (col),
      .Cout     (cout),
      .rd_valid (rd_valid),
      .busy     (busy),
      .done     (done)
   );

   function automatic int expect_read(input int v);
      int res;
      res = v;
`ifdef MEMC_SATURATE_EN
      if (v > 127) res = 127;
      if (v < -128) res = -128;
`endif
      return res;
   endfunction

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // model: a capture takes 2*DEPTH-1 enabled cycles, then the whole matrix is readable
   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_beats = 0;
         m_valid = 1'b0;
         m_cout  = 0;
         for (int r = 0; r < DEPTH; r++)
            for (int c = 0; c < DEPTH; c++)
               m_mat[r][c] = 0;
      end else begin
         m_valid = 1'b0;
         if (m_phase == 2 && rd_en && !start) begin
            m_valid = 1'b1;
            m_cout  = expect_read(m_mat[row][col]);
         end
         if (m_phase != 1 && start) begin
            m_phase = 1;
            m_beats = 0;
         end else if (m_phase == 1 && en) begin
            m_beats++;
            if (m_beats == NBEATS) begin
               m_phase = 2;
               for (int r = 0; r < DEPTH; r++)
                  for (int c = 0; c < DEPTH; c++)
                     m_mat[r][c] = stim[r][c];
            end
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         check("busy", busy, (m_phase == 1));
         check("done", done, (m_phase == 2));
         check("rd_valid", rd_valid, m_valid);
         check("cout", cout, m_cout);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_basic();
      for (int r = 0; r < DEPTH; r++)
         for (int x = 0; x < DEPTH; x++)
            stim[r][x] = 16 * r + x;
   endtask

   task automatic fill_diff();
      for (int r = 0; r < DEPTH; r++)
         for (int x = 0; x < DEPTH; x++)
            stim[r][x] = r - x;
   endtask

   // present beat b: lane x carries C[b-x][x], junk outside the window
   task automatic drive_cin(input int b);
      for (int x = 0; x < DEPTH; x++) begin
         int r;
         r = b - x;
         if (r >= 0 && r < DEPTH) cin[x] = BITS_C'(stim[r][x]);
         else                     cin[x] = BITS_C'($urandom);
      end
   endtask

   task automatic run_capture(input bit stall, input bit poke, input int abort_at,
                              input bit rd_with_start, output int done_beat);
      int b;
      int cyc;
      b = 0;
      cyc = 0;
      done_beat = -1;
      start = 1'b1;
      en = 1'b1;
      rd_en = rd_with_start;
      row = 3'd3;
      col = 3'd5;
      tick();
      start = 1'b0;
      rd_en = 1'b0;
      if (rd_with_start) check("rd_with_start", rd_valid, 1'b0);
      while (b < NBEATS && cyc < 200) begin
         drive_cin(b);
         if (b == abort_at) begin
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
            return;
         end
         en = stall ? (cyc % 2 == 1) : 1'b1;
         start = poke && (cyc % 3 == 1);
         tick();
         if (en) b++;
         if (done && done_beat < 0) done_beat = b;
         cyc++;
      end
      start = 1'b0;
      en = 1'b1;
   endtask

   task automatic do_read(input int r, input int c, output logic signed [31:0] val,
                          output logic vld);
      rd_en = 1'b1;
      row = 3'(r);
      col = 3'(c);
      tick();
      rd_en = 1'b0;
      val = cout;
      vld = rd_valid;
   endtask

   initial begin
      int db;
      logic signed [31:0] v1;
      logic signed [31:0] v2;
      logic vld1;
      logic vld2;

      rst = 1'b1; en = 1'b0; start = 1'b0; rd_en = 1'b0; row = '0; col = '0; cin = '0;
      fill_basic();
      tick();
      chk_on = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_cout", cout, 0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);

      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("idle_read", rd_valid, 1'b0);

      // basic drain
      fill_basic();
      run_capture(1'b0, 1'b0, -1, 1'b0, db);
      check("basic_done_beat", db, 15);
      do_read(3, 5, v1, vld1);
      check("basic_read_3_5", v1, 53);
      check("basic_read_vld", vld1, 1'b1);

      // stalled drain, launched from DONE with a read in the same cycle
      run_capture(1'b1, 1'b0, -1, 1'b1, db);
      check("stall_done_beat", db, 15);
      do_read(3, 5, v1, vld1);
      check("stall_read_3_5", v1, 53);
      do_read(6, 2, v1, vld1);
      check("stall_read_6_2", v1, 98);
      do_read(7, 7, v1, vld1);
      check("stall_read_7_7", v1, 119);

      // signed extremes, back-to-back reads
      fill_basic();
      stim[7][7] = -1;
      stim[0][0] = 8388607;
      run_capture(1'b0, 1'b0, -1, 1'b0, db);
      rd_en = 1'b1; row = 3'd7; col = 3'd7;
      tick();
      v1 = cout; vld1 = rd_valid;
      row = 3'd0; col = 3'd0;
      tick();
      rd_en = 1'b0;
      v2 = cout; vld2 = rd_valid;
      check("signed_read_7_7", v1, -1);
      check("b2b_vld1", vld1, 1'b1);
`ifdef MEMC_SATURATE_EN
      check("signed_read_0_0", v2, 127);
`else
      check("signed_read_0_0", v2, 8388607);
`endif
      check("b2b_vld2", vld2, 1'b1);

      // abort at beat 6, then restart with start pokes during capture
      fill_basic();
      run_capture(1'b0, 1'b0, 6, 1'b0, db);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      fill_diff();
      run_capture(1'b0, 1'b1, -1, 1'b0, db);
      check("restart_done_beat", db, 15);
      do_read(2, 6, v1, vld1);
      check("restart_read_2_6", v1, -4);
      do_read(7, 0, v1, vld1);
      check("restart_read_7_0", v1, 7);

`ifdef MEMC_SATURATE_EN
      fill_basic();
      stim[1][1] = 300;
      stim[1][2] = -300;
      stim[1][3] = -5;
      run_capture(1'b0, 1'b0, -1, 1'b0, db);
      do_read(1, 1, v1, vld1);
      check("sat_read_1_1", v1, 127);
      do_read(1, 2, v1, vld1);
      check("sat_read_1_2", v1, -128);
      do_read(1, 3, v1, vld1);
      check("sat_read_1_3", v1, -5);
`endif

      tick();
      tick();
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
